// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: default register
// addresses, transmitter FSM encoding and status-word bit positions.
package mmio_pkg;

  localparam logic [31:0] TX_ADDR_DEF   = 32'hFFFF_FF00;
  localparam logic [31:0] STAT_ADDR_DEF = 32'hFFFF_FF04;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_FULL_BIT = 1;
  localparam int STAT_OVF_BIT  = 2;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Small synchronous FIFO with first-word-fall-through output. A push into a
// full FIFO is accepted only when a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's store bus: stores to the TX
// register are queued in a FIFO and serialised on txd; a status word is readable.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] TX_ADDR      = TX_ADDR_DEF,
  parameter logic [31:0] STAT_ADDR    = STAT_ADDR_DEF,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_AW      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataaddr,
  input  logic [31:0] writedata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        busy,
  output logic        full
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  tx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    idx_q;
  logic [7:0]    shreg_q;
  logic          txd_q;
  logic          ovf_q;

  logic          tx_sel;
  logic          stat_sel;
  logic          push_req;
  logic          ovf_clr;
  logic          ovf_set;
  logic          baud_wrap;
  logic          pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          unused_wdata;

  assign tx_sel       = (dataaddr == TX_ADDR);
  assign stat_sel     = (dataaddr == STAT_ADDR);
  assign hit          = tx_sel || stat_sel;
  assign push_req     = memwrite && tx_sel;
  assign ovf_clr      = memwrite && stat_sel;
  assign unused_wdata = ^writedata[31:8];

  assign baud_wrap = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign cnt_d     = baud_wrap ? '0 : cnt_q + CW'(1);

  // Pops rely on the registered empty flag, so a fresh byte waits one edge.
  assign pop = !fifo_empty &&
               ((state_q == IDLE) || ((state_q == STOP) && baud_wrap));

  // A full FIFO still accepts a push when the same edge pops.
  assign ovf_set = push_req && fifo_full && !pop;

  assign txd  = txd_q;
  assign full = fifo_full;
  assign busy = (state_q != IDLE) || !fifo_empty;

  always_comb begin
    rdata = '0;
    if (stat_sel) begin
      rdata[STAT_BUSY_BIT] = busy;
      rdata[STAT_FULL_BIT] = fifo_full;
      rdata[STAT_OVF_BIT]  = ovf_q;
    end
  end

  sync_fifo #(
    .W  (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (writedata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pop) begin
            shreg_q <= fifo_dout;
            state_q <= START;
            txd_q   <= 1'b0;
          end else begin
            txd_q <= 1'b1;
          end
        end
        START: begin
          cnt_q <= cnt_d;
          if (baud_wrap) begin
            state_q <= DATA;
            idx_q   <= '0;
            txd_q   <= shreg_q[0];
          end
        end
        DATA: begin
          cnt_q <= cnt_d;
          if (baud_wrap) begin
            if (idx_q == 3'd7) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              idx_q   <= idx_q + 3'd1;
              shreg_q <= shreg_q >> 1;
              txd_q   <= shreg_q[1];
            end
          end
        end
        STOP: begin
          cnt_q <= cnt_d;
          if (baud_wrap) begin
            if (pop) begin
              shreg_q <= fifo_dout;
              state_q <= START;
              txd_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
              txd_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule
